// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// FSM state encoding and default parameter values.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Timeout counter for an outstanding data-memory access.
// Ports:
//   clk     in  pipeline clock
//   rst_n   in  asynchronous active-low reset
//   clr     in  synchronous clear (access not yet started)
//   en      in  count one cycle spent waiting on memory
//   expired out counting and the count has reached TIMEOUT-1
module mem_timeout_cnt
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned     CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = en & (r_cnt == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer. Issues the EX/MEM access on a
// valid/ready request channel, stalls the front of the pipeline while the
// access is outstanding, and returns load data to MEM/WB. A timeout aborts
// the access and sets a sticky bus error.
// Ports:
//   ex_mem_read/write/addr/wdata  access from the EX/MEM register
//   dmem_req_*                    registered request channel to data memory
//   dmem_rsp_valid/rdata          read response from data memory
//   stall                         hold PC, IF/ID, ID/EX, EX/MEM
//   mem_wb_bubble                 force MEM/WB control to NOP
//   mem_rdata                     load data to MEM/WB, valid in DONE
//   bus_err                       sticky timeout flag, cleared only by reset
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  output logic              dmem_req_valid,
  output logic              dmem_req_we,
  output logic [ADDR_W-1:0] dmem_req_addr,
  output logic [DATA_W-1:0] dmem_req_wdata,
  input  logic              dmem_req_ready,
  input  logic              dmem_rsp_valid,
  input  logic [DATA_W-1:0] dmem_rsp_rdata,
  output logic              stall,
  output logic              mem_wb_bubble,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);

  state_t            r_state;
  logic              r_req_valid;
  logic              r_req_we;
  logic [ADDR_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_req_wdata;
  logic [DATA_W-1:0] r_mem_rdata;
  logic              r_bus_err;

  logic w_access;
  logic w_waiting;
  logic w_expired;

  assign w_access  = ex_mem_read | ex_mem_write;
  assign w_waiting = (r_state == ST_REQ) || (r_state == ST_RSP);

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (r_state == ST_IDLE),
    .en      (w_waiting),
    .expired (w_expired)
  );

  // Completion wins over an expiry in the same cycle. DONE never samples
  // EX/MEM: it still holds the access just finished, so issuing from there
  // would repeat it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_req_valid <= 1'b1;
            r_req_we    <= ex_mem_write;
            r_req_addr  <= ex_mem_addr;
            r_req_wdata <= ex_mem_wdata;
            r_state     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_req_ready) begin
            r_req_valid <= 1'b0;
            r_state     <= r_req_we ? ST_DONE : ST_RSP;
          end else if (w_expired) begin
            r_req_valid <= 1'b0;
            r_bus_err   <= 1'b1;
            r_mem_rdata <= '0;
            r_state     <= ST_DONE;
          end
        end
        ST_RSP: begin
          if (dmem_rsp_valid) begin
            r_mem_rdata <= dmem_rsp_rdata;
            r_state     <= ST_DONE;
          end else if (w_expired) begin
            r_bus_err   <= 1'b1;
            r_mem_rdata <= '0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stall starts combinationally in the IDLE cycle that sees the access.
  assign stall          = w_waiting | ((r_state == ST_IDLE) & w_access);
  assign mem_wb_bubble  = stall;

  assign dmem_req_valid = r_req_valid;
  assign dmem_req_we    = r_req_we;
  assign dmem_req_addr  = r_req_addr;
  assign dmem_req_wdata = r_req_wdata;
  assign mem_rdata      = r_mem_rdata;
  assign bus_err        = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_mem_wdata;
  logic        dmem_req_valid;
  logic        dmem_req_we;
  logic [31:0] dmem_req_addr;
  logic [31:0] dmem_req_wdata;
  logic        dmem_req_ready;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rsp_rdata;
  logic        stall;
  logic        mem_wb_bubble;
  logic [31:0] mem_rdata;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_access_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_mem_addr    (ex_mem_addr),
    .ex_mem_wdata   (ex_mem_wdata),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_we    (dmem_req_we),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_ready (dmem_req_ready),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rsp_rdata (dmem_rsp_rdata),
    .stall          (stall),
    .mem_wb_bubble  (mem_wb_bubble),
    .mem_rdata      (mem_rdata),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
  } req_t;

  req_t reqs[$];

  always @(posedge clk) begin
    if (rst_n && dmem_req_valid && dmem_req_ready) begin
      reqs.push_back('{we: dmem_req_we, addr: dmem_req_addr});
    end
  end

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic        ready, rsp_v;
    logic [31:0] rsp_d;
    logic        e_valid, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic rd, wr, input logic [31:0] addr, wdata,
    input logic ready, rsp_v, input logic [31:0] rsp_d,
    input logic e_valid, e_we, input logic [31:0] e_addr, e_wdata,
    input logic e_stall, input logic [31:0] e_rdata, input logic e_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ready = ready; v.rsp_v = rsp_v; v.rsp_d = rsp_d;
    v.e_valid = e_valid; v.e_we = e_we; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_stall = e_stall; v.e_rdata = e_rdata; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one access with ready held high; the response (if any) arrives
  // rsp_lat cycles after acceptance (-1 = never). Returns in the first
  // non-stalled cycle with the number of stalled cycles seen.
  task automatic run_access(input logic rd, wr, input logic [31:0] a, wd,
                            input int rsp_lat, input logic [31:0] rdat,
                            output int n_stall, output logic timed_out);
    int since_acc;
    since_acc      = -1;
    ex_mem_read    = rd;
    ex_mem_write   = wr;
    ex_mem_addr    = a;
    ex_mem_wdata   = wd;
    dmem_req_ready = 1'b1;
    n_stall        = 0;
    timed_out      = 1'b1;
    for (int c = 0; c < 64; c++) begin
      dmem_rsp_valid = (since_acc >= 0) && (since_acc == rsp_lat);
      dmem_rsp_rdata = dmem_rsp_valid ? rdat : 32'h0;
      #2;
      if (!stall) begin
        timed_out = 1'b0;
        break;
      end
      n_stall++;
      if (since_acc >= 0) since_acc++;
      else if (dmem_req_valid && dmem_req_ready) since_acc = 0;
      @(negedge clk);
    end
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    ex_mem_read    = 1'b0;
    ex_mem_write   = 1'b0;
    ex_mem_addr    = '0;
    ex_mem_wdata   = '0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
  endtask

  int          n_stall;
  logic        to;
  logic [31:0] exp_addr[4];
  logic        exp_we[4];

  initial begin
    //              rd wr addr        wdata         rdy rv rsp_d         | val we addr        wdata         stl rdata         err
    vecs[0]  = mk(0, 0, 32'h00, 32'h0,         1, 0, 32'h0,         0, 0, 32'h00, 32'h0,         0, 32'h0,         0);
    vecs[1]  = mk(1, 0, 32'h10, 32'h0,         1, 0, 32'h0,         0, 0, 32'h00, 32'h0,         1, 32'h0,         0);
    vecs[2]  = mk(1, 0, 32'h10, 32'h0,         1, 0, 32'h0,         1, 0, 32'h10, 32'h0,         1, 32'h0,         0);
    vecs[3]  = mk(1, 0, 32'h10, 32'h0,         1, 1, 32'hCAFEF00D,  0, 0, 32'h10, 32'h0,         1, 32'h0,         0);
    vecs[4]  = mk(1, 0, 32'h10, 32'h0,         1, 0, 32'h0,         0, 0, 32'h10, 32'h0,         0, 32'hCAFEF00D,  0);
    vecs[5]  = mk(0, 1, 32'h30, 32'hDEADBEEF,  1, 0, 32'h0,         0, 0, 32'h10, 32'h0,         1, 32'hCAFEF00D,  0);
    vecs[6]  = mk(0, 1, 32'h30, 32'hDEADBEEF,  1, 0, 32'h0,         1, 1, 32'h30, 32'hDEADBEEF,  1, 32'hCAFEF00D,  0);
    vecs[7]  = mk(0, 1, 32'h30, 32'hDEADBEEF,  1, 0, 32'h0,         0, 1, 32'h30, 32'hDEADBEEF,  0, 32'hCAFEF00D,  0);
    vecs[8]  = mk(0, 0, 32'h00, 32'h0,         1, 0, 32'h0,         0, 1, 32'h30, 32'hDEADBEEF,  0, 32'hCAFEF00D,  0);
    vecs[9]  = mk(0, 1, 32'h20, 32'h12345678,  0, 0, 32'h0,         0, 1, 32'h30, 32'hDEADBEEF,  1, 32'hCAFEF00D,  0);
    vecs[10] = mk(0, 1, 32'h20, 32'h12345678,  0, 0, 32'h0,         1, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[11] = mk(0, 1, 32'h20, 32'h12345678,  0, 1, 32'h0BADBAD0,  1, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[12] = mk(0, 1, 32'h20, 32'h12345678,  0, 0, 32'h0,         1, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[13] = mk(0, 1, 32'h20, 32'h12345678,  0, 0, 32'h0,         1, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[14] = mk(0, 1, 32'h20, 32'h12345678,  1, 0, 32'h0,         1, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[15] = mk(0, 1, 32'h20, 32'h12345678,  1, 0, 32'h0,         0, 1, 32'h20, 32'h12345678,  0, 32'hCAFEF00D,  0);
    vecs[16] = mk(1, 1, 32'h40, 32'h55AA55AA,  1, 0, 32'h0,         0, 1, 32'h20, 32'h12345678,  1, 32'hCAFEF00D,  0);
    vecs[17] = mk(1, 1, 32'h40, 32'h55AA55AA,  1, 0, 32'h0,         1, 1, 32'h40, 32'h55AA55AA,  1, 32'hCAFEF00D,  0);
    vecs[18] = mk(1, 1, 32'h40, 32'h55AA55AA,  1, 0, 32'h0,         0, 1, 32'h40, 32'h55AA55AA,  0, 32'hCAFEF00D,  0);
    vecs[19] = mk(0, 0, 32'h00, 32'h0,         1, 0, 32'h0,         0, 1, 32'h40, 32'h55AA55AA,  0, 32'hCAFEF00D,  0);

    exp_we[0] = 1'b0; exp_addr[0] = 32'h10;
    exp_we[1] = 1'b1; exp_addr[1] = 32'h30;
    exp_we[2] = 1'b1; exp_addr[2] = 32'h20;
    exp_we[3] = 1'b1; exp_addr[3] = 32'h40;

    rst_n          = 1'b0;
    ex_mem_read    = 1'b0;
    ex_mem_write   = 1'b0;
    ex_mem_addr    = '0;
    ex_mem_wdata   = '0;
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;

    repeat (2) @(negedge clk);
    #2;
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_stall",     32'(stall),          32'd0);
    chk("rst_bubble",    32'(mem_wb_bubble),  32'd0);
    chk("rst_rdata",     mem_rdata,           32'h0);
    chk("rst_bus_err",   32'(bus_err),        32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      ex_mem_read    = vecs[i].rd;
      ex_mem_write   = vecs[i].wr;
      ex_mem_addr    = vecs[i].addr;
      ex_mem_wdata   = vecs[i].wdata;
      dmem_req_ready = vecs[i].ready;
      dmem_rsp_valid = vecs[i].rsp_v;
      dmem_rsp_rdata = vecs[i].rsp_d;
      #2;
      chk($sformatf("v%0d_req_valid", i), 32'(dmem_req_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_req_we", i),    32'(dmem_req_we),    32'(vecs[i].e_we));
      chk($sformatf("v%0d_req_addr", i),  dmem_req_addr,       vecs[i].e_addr);
      chk($sformatf("v%0d_req_wdata", i), dmem_req_wdata,      vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i),     32'(stall),          32'(vecs[i].e_stall));
      chk($sformatf("v%0d_bubble", i),    32'(mem_wb_bubble),  32'(vecs[i].e_stall));
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata,           vecs[i].e_rdata);
      chk($sformatf("v%0d_bus_err", i),   32'(bus_err),        32'(vecs[i].e_err));
    end

    // Load with no response: 1 IDLE stall cycle + 16 cycles in REQ+RSP.
    go_idle();
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h50, 32'h0, -1, 32'h0, n_stall, to);
    chk("tmo_bounded",   32'(to),        32'd0);
    chk("tmo_stalls",    32'(n_stall),   32'd17);
    chk("tmo_bus_err",   32'(bus_err),   32'd1);
    chk("tmo_rdata",     mem_rdata,      32'h0);
    chk("tmo_req_valid", 32'(dmem_req_valid), 32'd0);

    // Good load after the timeout: bus_err must persist.
    go_idle();
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h60, 32'h0, 0, 32'hAABBCCDD, n_stall, to);
    chk("ld2_bounded", 32'(to),      32'd0);
    chk("ld2_stalls",  32'(n_stall), 32'd3);
    chk("ld2_rdata",   mem_rdata,    32'hAABBCCDD);
    chk("ld2_bus_err", 32'(bus_err), 32'd1);

    // Slower response: two idle response cycles add two stall cycles.
    go_idle();
    @(negedge clk);
    run_access(1'b1, 1'b0, 32'h64, 32'h0, 2, 32'h13572468, n_stall, to);
    chk("ld3_bounded", 32'(to),      32'd0);
    chk("ld3_stalls",  32'(n_stall), 32'd5);
    chk("ld3_rdata",   mem_rdata,    32'h13572468);

    // Reset while waiting in RSP, then a late response that must be ignored.
    go_idle();
    @(negedge clk);
    ex_mem_read    = 1'b1;
    ex_mem_addr    = 32'h70;
    dmem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rsp_wait_stall", 32'(stall),          32'd1);
    chk("rsp_wait_valid", 32'(dmem_req_valid), 32'd0);
    rst_n       = 1'b0;
    ex_mem_read = 1'b0;
    #1;
    chk("arst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("arst_stall",     32'(stall),          32'd0);
    chk("arst_bubble",    32'(mem_wb_bubble),  32'd0);
    chk("arst_rdata",     mem_rdata,           32'h0);
    chk("arst_bus_err",   32'(bus_err),        32'd0);
    @(negedge clk);
    rst_n          = 1'b1;
    dmem_rsp_valid = 1'b1;
    dmem_rsp_rdata = 32'h77777777;
    #2;
    chk("late_rsp_stall", 32'(stall), 32'd0);
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    #2;
    chk("late_rsp_rdata", mem_rdata,           32'h0);
    chk("late_rsp_valid", 32'(dmem_req_valid), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("no_replay_valid", 32'(dmem_req_valid), 32'd0);

    chk("req_count", 32'(reqs.size()), 32'd8);
    for (int i = 0; i < 4; i++) begin
      if (i < reqs.size()) begin
        chk($sformatf("req%0d_we", i),   32'(reqs[i].we), 32'(exp_we[i]));
        chk($sformatf("req%0d_addr", i), reqs[i].addr,    exp_addr[i]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
